button_event_classifier: RTL and testbench

- Sits directly downstream of the button debouncer and consumes its clean level output.
- Converts the debounced level into single-cycle, registered gesture events: press/release edges, short press, long press, auto-repeat while held, and double click.
- Lets control FSMs act on intent instead of polling raw levels.

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_edge_detect.sv | 45 ++++
 rtl/button_event_classifier.sv | 167 ++++++++++++++++
 tb/tb_button_event_classifier.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button gesture classifier:
//   - state_t      : FSM state encoding (3 bits)
//   - DEF_*_CYCLES : default timing constants for the 50 MHz board clock
//   - DEF_CNT_W    : default width of the shared timing counter
// ---------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    WAIT_GAP = 3'd2,
    PRESS2   = 3'd3,
    HOLD     = 3'd4
  } state_t;

  // 2 s hold, 300 ms click gap, 200 ms repeat period at 50 MHz.
  localparam int unsigned DEF_LONG_CYCLES   = 32'd100_000_000;
  localparam int unsigned DEF_GAP_CYCLES    = 32'd15_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd10_000_000;
  localparam int unsigned DEF_CNT_W         = 32;

endpackage

// File: rtl/button_edge_detect.sv
// ---------------------------------------------------------------------------
// button_edge_detect
// Tracks the previous debounced level and derives edge strobes.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   btn_level     in   debounced button level (1 = pressed)
//   rise          out  combinational 0->1 edge (same cycle as the new level)
//   fall          out  combinational 1->0 edge (same cycle as the new level)
//   press_pulse   out  registered copy of rise (1-cycle latency)
//   release_pulse out  registered copy of fall (1-cycle latency)
// ---------------------------------------------------------------------------
module button_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic rise,
  output logic fall,
  output logic press_pulse,
  output logic release_pulse
);

  logic prev_level_reg;
  logic press_pulse_reg;
  logic release_pulse_reg;

  assign rise = btn_level & ~prev_level_reg;
  assign fall = ~btn_level & prev_level_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_level_reg    <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
    end else begin
      prev_level_reg    <= btn_level;
      press_pulse_reg   <= rise;
      release_pulse_reg <= fall;
    end
  end

  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;

endmodule

// File: rtl/button_event_classifier.sv
// ---------------------------------------------------------------------------
// button_event_classifier
// Turns a debounced button level into single-cycle registered gesture events.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   btn_level     in   debounced button level (1 = pressed)
//   press_pulse   out  one-cycle pulse per 0->1 edge
//   release_pulse out  one-cycle pulse per 1->0 edge
//   short_press   out  single click confirmed (gap window expired)
//   long_press    out  hold reached LONG_CYCLES
//   repeat_pulse  out  every REPEAT_CYCLES while held after long_press
//   double_click  out  second click released within the gap window
//   busy          out  FSM is not in IDLE
// ---------------------------------------------------------------------------
module button_event_classifier
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic busy
);

  // Terminal counts: an expiry fires on the cycle the counter sits at N-1.
  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic rise;
  logic fall;

  button_edge_detect u_edge (
    .clk           (clk),
    .reset         (reset),
    .btn_level     (btn_level),
    .rise          (rise),
    .fall          (fall),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             short_reg, short_next;
  logic             long_reg, long_next;
  logic             repeat_reg, repeat_next;
  logic             double_reg, double_next;
  logic             busy_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      short_reg  <= 1'b0;
      long_reg   <= 1'b0;
      repeat_reg <= 1'b0;
      double_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      short_reg  <= short_next;
      long_reg   <= long_next;
      repeat_reg <= repeat_next;
      double_reg <= double_next;
      busy_reg   <= (state_next != IDLE);
    end
  end

  // Edges always win over a counter expiry in the same cycle; every state
  // change clears the counter, so it can never run past its terminal value.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    double_next = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rise) begin
          state_next = PRESS1;
        end
      end

      PRESS1: begin
        if (fall) begin
          state_next = WAIT_GAP;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_TERM) begin
          long_next  = 1'b1;
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      WAIT_GAP: begin
        if (rise) begin
          state_next = PRESS2;
          cnt_next   = '0;
        end else if (cnt_reg == GAP_TERM) begin
          short_next = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      PRESS2: begin
        if (fall) begin
          double_next = 1'b1;
          state_next  = IDLE;
          cnt_next    = '0;
        end else if (cnt_reg == LONG_TERM) begin
          // Second press held long: the pending first click is dropped.
          long_next  = 1'b1;
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      HOLD: begin
        if (fall) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == REPEAT_TERM) begin
          repeat_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign short_press  = short_reg;
  assign long_press   = long_reg;
  assign repeat_pulse = repeat_reg;
  assign double_click = double_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_button_event_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_event_classifier
// Directed gesture scenarios plus random press/release traffic, compared
// cycle by cycle against a timestamp-based gesture model.
// ---------------------------------------------------------------------------
module tb_button_event_classifier;

  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int REP  = 3;

  localparam int M_IDLE = 0;
  localparam int M_P1   = 1;
  localparam int M_GAP  = 2;
  localparam int M_P2   = 3;
  localparam int M_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_level;
  logic press_pulse, release_pulse, short_press, long_press;
  logic repeat_pulse, double_click, busy;

  always #5 clk = ~clk;

  button_event_classifier #(
    .LONG_CYCLES   (LONG),
    .GAP_CYCLES    (GAP),
    .REPEAT_CYCLES (REP),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .double_click  (double_click),
    .busy          (busy)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  string cur_tag = "init";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Gesture model: phase plus the cycle at which the phase began; expiries
  // are judged by elapsed time since phase entry.
  int     m_mode;
  bit     m_prev;
  longint now_cyc, t_entry;
  logic [6:0] m_out;   // {busy, double, repeat, long, short, release, press}

  int ev_press, ev_rel, ev_short, ev_long, ev_rep, ev_dbl;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_prev  = 1'b0;
    t_entry = now_cyc;
    m_out   = '0;
  endtask

  task automatic enter(input int mode);
    m_mode  = mode;
    t_entry = now_cyc;
  endtask

  task automatic model_edge(input bit b);
    bit rise_m, fall_m, sh, lg, rp, db;
    longint el;
    rise_m = b & ~m_prev;
    fall_m = ~b & m_prev;
    sh = 0; lg = 0; rp = 0; db = 0;
    now_cyc++;
    el = now_cyc - t_entry;
    case (m_mode)
      M_IDLE: if (rise_m) enter(M_P1);
      M_P1: begin
        if (fall_m) enter(M_GAP);
        else if (el == LONG) begin lg = 1; enter(M_HOLD); end
      end
      M_GAP: begin
        if (rise_m) enter(M_P2);
        else if (el == GAP) begin sh = 1; enter(M_IDLE); end
      end
      M_P2: begin
        if (fall_m) begin db = 1; enter(M_IDLE); end
        else if (el == LONG) begin lg = 1; enter(M_HOLD); end
      end
      default: begin
        if (fall_m) enter(M_IDLE);
        else if (el % REP == 0) rp = 1;
      end
    endcase
    m_prev = b;
    m_out  = {(m_mode != M_IDLE), db, rp, lg, sh, fall_m, rise_m};
  endtask

  function automatic logic [6:0] dut_out();
    return {busy, double_click, repeat_pulse, long_press, short_press,
            release_pulse, press_pulse};
  endfunction

  task automatic clear_counts();
    ev_press = 0; ev_rel = 0; ev_short = 0; ev_long = 0; ev_rep = 0; ev_dbl = 0;
  endtask

  // Called at a negedge: drive, let one active edge happen, check at negedge.
  task automatic step(input bit b);
    logic [6:0] got;
    btn_level = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    got = dut_out();
    check_val(cur_tag, {25'd0, got}, {25'd0, m_out});
    ev_press += int'(press_pulse);
    ev_rel   += int'(release_pulse);
    ev_short += int'(short_press);
    ev_long  += int'(long_press);
    ev_rep   += int'(repeat_pulse);
    ev_dbl   += int'(double_click);
  endtask

  task automatic run_seg(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic scenario(input string name, input int h1, input int l1,
                          input int h2, input int l2, input int e_short,
                          input int e_long, input int e_rep, input int e_dbl);
    cur_tag = name;
    clear_counts();
    run_seg(1'b1, h1);
    run_seg(1'b0, l1);
    if (h2 > 0) begin
      run_seg(1'b1, h2);
    end
    run_seg(1'b0, l2);
    check_val({name, "_short"}, ev_short, e_short);
    check_val({name, "_long"}, ev_long, e_long);
    check_val({name, "_repeat"}, ev_rep, e_rep);
    check_val({name, "_double"}, ev_dbl, e_dbl);
    check_val({name, "_press"}, ev_press, (h2 > 0) ? 2 : 1);
    check_val({name, "_busy_end"}, {31'd0, busy}, 0);
    $display("scenario %s: short=%0d long=%0d repeat=%0d double=%0d", name,
             ev_short, ev_long, ev_rep, ev_dbl);
  endtask

  initial begin
    bit lvl;
    now_cyc = 0;
    reset = 1'b0;
    btn_level = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset_state", {25'd0, dut_out()}, 32'd0);
    reset = 1'b1;

    // Single click, long hold, double click, late second click, races.
    scenario("single_click", 3, 12, 0, 0, 1, 0, 0, 0);
    scenario("long_hold", 16, 12, 0, 0, 0, 1, 2, 0);
    scenario("double_click", 2, 2, 2, 12, 0, 0, 0, 1);
    scenario("late_second", 2, 5, 2, 12, 2, 0, 0, 0);
    scenario("release_at_long", 8, 12, 0, 0, 1, 0, 0, 0);
    scenario("rise_at_gap_end", 2, 4, 2, 12, 0, 0, 0, 1);
    scenario("second_held_long", 2, 2, 12, 6, 0, 1, 1, 0);

    // Reset in the middle of HOLD, button kept pressed throughout.
    cur_tag = "hold_then_reset";
    run_seg(1'b1, 12);
    check_val("hold_busy", {31'd0, busy}, 1);
    reset = 1'b0;
    #1;
    check_val("reset_async_outputs", {25'd0, dut_out()}, 32'd0);
    model_reset();
    @(negedge clk);
    check_val("reset_held_outputs", {25'd0, dut_out()}, 32'd0);
    reset = 1'b1;
    cur_tag = "after_reset";
    clear_counts();
    run_seg(1'b1, 5);
    check_val("after_reset_gestures", ev_short + ev_long + ev_rep + ev_dbl, 0);
    run_seg(1'b0, 12);
    $display("scenario reset_mid_hold: gestures_after_reset=%0d",
             ev_short + ev_long + ev_rep + ev_dbl);

    // Random press/release traffic.
    cur_tag = "random";
    lvl = 1'b0;
    for (int s = 0; s < 400; s++) begin
      lvl = ~lvl;
      run_seg(lvl, $urandom_range(1, 14));
    end
    run_seg(1'b0, 12);
    check_val("random_end_idle", {31'd0, busy}, 0);
    $display("random traffic: %0d cycles modelled", now_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
